// File: rtl/neokeon_pkg.sv
// neokeon_pkg: shared state encoding, round count and round-constant rules
// for the Neokeon-128 round controller.
package neokeon_pkg;

    localparam int NR = 16;
    localparam logic [7:0] RC_INIT_ENC = 8'h80;
    localparam logic [7:0] RC_INIT_DEC = 8'hD4;
    localparam logic [7:0] RC_POLY     = 8'h1B;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KEYPREP,
        ROUND,
        FINAL,
        WRITE,
        DONE
    } stateT;

    function automatic logic [7:0] rcFwd(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? RC_POLY : 8'h00);
    endfunction

    // Exact inverse of rcFwd, so decryption walks the same constants backwards.
    function automatic logic [7:0] rcRev(input logic [7:0] rc);
        return rc[0] ? (((rc ^ RC_POLY) >> 1) | 8'h80) : (rc >> 1);
    endfunction

endpackage

// File: rtl/neokeon_rc_gen.sv
// neokeon_rc_gen: round-constant register, preset on load and stepped
// forward (encrypt) or backward (decrypt) once per round.
module neokeon_rc_gen
    import neokeon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic       rev,
    output logic [7:0] rc
);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            rc <= 8'h00;
        else if (load)
            rc <= rev ? RC_INIT_DEC : RC_INIT_ENC;
        else if (step)
            rc <= rev ? rcRev(rc) : rcFwd(rc);

endmodule

// File: rtl/neokeon_round_ctrl.sv
// neokeon_round_ctrl: sequences load, optional key prep, NR rounds, output
// transform and data-out write for the Neokeon core; all outputs registered.
module neokeon_round_ctrl
    import neokeon_pkg::*;
(
    input  logic       inClk,
    input  logic       inRst,
    input  logic       inStart,
    input  logic       inMode,
    output logic       outLoad,
    output logic       outKeyPrep,
    output logic       outRoundEn,
    output logic       outFinal,
    output logic       outDecrypt,
    output logic [7:0] outRc,
    output logic [4:0] outRound,
    output logic       outWrOut,
    output logic       outBusy,
    output logic       outDone
);

    stateT      state;
    logic [4:0] round;
    logic       rcLoad;
    logic       rcStep;
    logic       rcDir;

    // The constant is preset on the accepting edge so it is already valid in LOAD.
    assign rcLoad   = (state == IDLE) && inStart;
    assign rcStep   = (state == ROUND);
    assign rcDir    = (state == IDLE) ? inMode : outDecrypt;
    assign outRound = round;

    neokeon_rc_gen rcGen (
        .clk (inClk),
        .rst (inRst),
        .load(rcLoad),
        .step(rcStep),
        .rev (rcDir),
        .rc  (outRc)
    );

    always_ff @(posedge inClk or posedge inRst)
        if (inRst) begin
            state      <= IDLE;
            round      <= 5'd0;
            outLoad    <= 1'b0;
            outKeyPrep <= 1'b0;
            outRoundEn <= 1'b0;
            outFinal   <= 1'b0;
            outWrOut   <= 1'b0;
            outDone    <= 1'b0;
            outBusy    <= 1'b0;
            outDecrypt <= 1'b0;
        end else begin
            outLoad    <= 1'b0;
            outKeyPrep <= 1'b0;
            outRoundEn <= 1'b0;
            outFinal   <= 1'b0;
            outWrOut   <= 1'b0;
            outDone    <= 1'b0;
            case (state)
                IDLE:
                    if (inStart) begin
                        state      <= LOAD;
                        outLoad    <= 1'b1;
                        outBusy    <= 1'b1;
                        outDecrypt <= inMode;
                    end
                LOAD:
                    if (outDecrypt) begin
                        state      <= KEYPREP;
                        outKeyPrep <= 1'b1;
                    end else begin
                        state      <= ROUND;
                        outRoundEn <= 1'b1;
                    end
                KEYPREP: begin
                    state      <= ROUND;
                    outRoundEn <= 1'b1;
                end
                ROUND:
                    if (round == 5'(NR - 1)) begin
                        state    <= FINAL;
                        round    <= 5'd0;
                        outFinal <= 1'b1;
                    end else begin
                        round      <= round + 5'd1;
                        outRoundEn <= 1'b1;
                    end
                FINAL: begin
                    state    <= WRITE;
                    outWrOut <= 1'b1;
                end
                WRITE: begin
                    state   <= DONE;
                    outDone <= 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    outBusy    <= 1'b0;
                    outDecrypt <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end

endmodule
